// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry layout for the instruction-fetch unit.
package fetch_pkg;

   localparam int DEF_ADDR_W   = 12;
   localparam int DEF_INSN_W   = 32;
   localparam int DEF_DEPTH    = 4;
   localparam int DEF_RESET_PC = 0;

   // Queue entry at the default widths; the queue itself stores {insn, pc} packed the same way.
   typedef struct packed {
      logic [DEF_INSN_W-1:0] insn;
      logic [DEF_ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {insn, pc} entries with simultaneous push/pop and a synchronous flush.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int W     = DEF_INSN_W + DEF_ADDR_W,
   parameter int DEPTH = DEF_DEPTH,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head_data,
   output logic          head_valid,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop     = pop && (count != '0);
   assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
   assign head_valid = (count != '0);
   assign head_data  = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clock) begin
      if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch unit: owns the PC, issues one imem read per cycle and queues returns for decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                INSN_W   = DEF_INSN_W,
   parameter int                DEPTH    = DEF_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
   localparam int               CW       = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_req,
   input  logic [INSN_W-1:0] imem_data,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              insn_valid,
   input  logic              insn_ready,
   output logic [INSN_W-1:0] insn,
   output logic [ADDR_W-1:0] insn_pc,
   output logic [ADDR_W-1:0] insn_pc_next,
   output logic [CW-1:0]     queue_count
);

   localparam int W = INSN_W + ADDR_W;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] pending_pc;
   logic              pending;
   logic [CW:0]       in_use;
   logic              push;
   logic              pop;
   logic [W-1:0]      head_data;

   // In-flight fetches reserve a queue slot, so a returning instruction always has room.
   assign in_use    = {1'b0, queue_count} + (CW+1)'(pending);
   assign imem_req  = !reset && !redirect && (in_use < (CW+1)'(DEPTH));
   assign imem_addr = fetch_pc;

   // Decode handshake: an entry transfers on a cycle with insn_valid && insn_ready; insn_valid
   // never depends on insn_ready, and a redirect cycle transfers nothing.
   assign push = pending && !redirect;
   assign pop  = insn_valid && insn_ready && !redirect;

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc   <= RESET_PC;
         pending    <= 1'b0;
         pending_pc <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         pending  <= 1'b0;
      end else if (imem_req) begin
         fetch_pc   <= fetch_pc + ADDR_W'(1);
         pending    <= 1'b1;
         pending_pc <= fetch_pc;
      end else begin
         pending <= 1'b0;
      end
   end

   fetch_queue #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clock      (clock),
      .reset      (reset),
      .flush      (redirect),
      .push       (push),
      .push_data  ({imem_data, pending_pc}),
      .pop        (pop),
      .head_data  (head_data),
      .head_valid (insn_valid),
      .count      (queue_count)
   );

   assign insn         = head_data[W-1:ADDR_W];
   assign insn_pc      = head_data[ADDR_W-1:0];
   assign insn_pc_next = insn_pc + ADDR_W'(1);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized ready/redirect traffic.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic [11:0] redirect_pc = '0;
   logic        insn_ready = 1'b0;

   logic [11:0] imem_addr, insn_pc, insn_pc_next, last_addr;
   logic        imem_req, insn_valid;
   logic [31:0] imem_data, insn;
   logic [2:0]  queue_count;

   logic [11:0] imem_addr_b, insn_pc_b, insn_pc_next_b, last_addr_b;
   logic        imem_req_b, insn_valid_b;
   logic [31:0] imem_data_b, insn_b;
   logic [2:0]  queue_count_b;

   int errors = 0;
   int checks = 0;
   int pops   = 0;
   logic [31:0] exp_q[$];

   always #5 clock = ~clock;

   // Memory model: returns address + 0x100 for the address presented one cycle earlier.
   always @(posedge clock) begin
      last_addr   <= imem_addr;
      last_addr_b <= imem_addr_b;
   end
   assign imem_data   = 32'(last_addr) + 32'h100;
   assign imem_data_b = 32'(last_addr_b) + 32'h100;

   fetch_unit u_dut (
      .clock        (clock),
      .reset        (reset),
      .imem_addr    (imem_addr),
      .imem_req     (imem_req),
      .imem_data    (imem_data),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .insn_valid   (insn_valid),
      .insn_ready   (insn_ready),
      .insn         (insn),
      .insn_pc      (insn_pc),
      .insn_pc_next (insn_pc_next),
      .queue_count  (queue_count)
   );

   fetch_unit #(.RESET_PC(12'hFFE)) u_dut_wrap (
      .clock        (clock),
      .reset        (reset),
      .imem_addr    (imem_addr_b),
      .imem_req     (imem_req_b),
      .imem_data    (imem_data_b),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .insn_valid   (insn_valid_b),
      .insn_ready   (insn_ready),
      .insn         (insn_b),
      .insn_pc      (insn_pc_b),
      .insn_pc_next (insn_pc_next_b),
      .queue_count  (queue_count_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference stream: after reset or redirect, delivered PCs run base, base+1, ... modulo 4096.
   task automatic restart_model(input logic [11:0] base);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(base + 12'(i)));
   endtask

   task automatic drive(input logic r, input logic rd, input logic [11:0] rpc, input logic rdy);
      reset       = r;
      redirect    = rd;
      redirect_pc = rpc;
      insn_ready  = rdy;
      #1;
   endtask

   task automatic tick();
      logic [31:0] e;
      if (!reset && !redirect && insn_valid && insn_ready) begin
         e = exp_q.pop_front();
         check("pop_pc", 32'(insn_pc), e);
         check("pop_insn", insn, e + 32'h100);
         check("pop_pc_next", 32'(insn_pc_next), 32'(e[11:0] + 12'd1));
         exp_q.push_back(32'(e[11:0] + 12'd8));
         pops++;
      end
      @(posedge clock);
      if (reset) restart_model(12'h000);
      else if (redirect) restart_model(redirect_pc);
      #2;
   endtask

   initial begin
      int issues;
      int pops0;
      logic [11:0] pb;

      // Reset state
      drive(1, 0, 0, 1);
      tick();
      drive(1, 0, 0, 1);
      check("rst_req", imem_req, 0);
      check("rst_valid", insn_valid, 0);
      check("rst_count", queue_count, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_addr_wrap", imem_addr_b, 12'hFFE);
      tick();

      // Streaming with ready held high; second instance crosses the address wrap
      for (int k = 0; k < 12; k++) begin
         drive(0, 0, 0, 1);
         check("t1_addr", imem_addr, k);
         check("t1_req", imem_req, 1);
         check("t1_addr_wrap", imem_addr_b, 12'(12'hFFE + 12'(k)));
         if (k < 2) begin
            check("t1_valid_early", insn_valid, 0);
            check("t1_valid_early_wrap", insn_valid_b, 0);
         end else begin
            pb = 12'(12'hFFE + 12'(k - 2));
            check("t1_valid", insn_valid, 1);
            check("t1_pc", insn_pc, k - 2);
            check("t1_valid_wrap", insn_valid_b, 1);
            check("t1_pc_wrap", insn_pc_b, pb);
            check("t1_insn_wrap", insn_b, 32'(pb) + 32'h100);
            check("t1_pc_next_wrap", insn_pc_next_b, 12'(pb + 12'd1));
         end
         if (k == 3) check("t1_fff_next", insn_pc_next_b, 12'h000);
         if (k == 4) check("t1_wrap_zero", insn_pc_b, 12'h000);
         tick();
      end

      // Back-pressure from reset: fill, then drain in order
      drive(1, 0, 0, 0);
      tick();
      issues = 0;
      for (int k = 0; k < 10; k++) begin
         drive(0, 0, 0, 0);
         if (imem_req) issues++;
         tick();
      end
      drive(0, 0, 0, 0);
      check("t2_count_full", queue_count, 4);
      check("t2_issues", issues, 4);
      check("t2_req_stopped", imem_req, 0);
      pops0 = pops;
      for (int j = 0; j < 12; j++) begin
         drive(0, 0, 0, 1);
         if (j == 1) check("t2_reissue", imem_req, 1);
         tick();
      end
      check("t2_drained", (pops - pops0) >= 4, 1);

      // Redirect coinciding with a return and a pop
      drive(1, 0, 0, 1);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 1);
         tick();
      end
      drive(0, 1, 12'h0A5, 1);
      check("t3_pre_valid", insn_valid, 1);
      check("t3_req_in_redirect", imem_req, 0);
      tick();
      drive(0, 0, 0, 1);
      check("t3_valid_flushed", insn_valid, 0);
      check("t3_count_flushed", queue_count, 0);
      check("t3_addr", imem_addr, 12'h0A5);
      check("t3_req", imem_req, 1);
      tick();
      drive(0, 0, 0, 1);
      check("t3_valid_t2", insn_valid, 0);
      tick();
      drive(0, 0, 0, 1);
      check("t3_valid_t3", insn_valid, 1);
      check("t3_first_pc", insn_pc, 12'h0A5);
      tick();

      // Reset mid-stream with three queued entries and one in flight from 0x300
      drive(0, 1, 12'h300, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0);
      check("t5_pre_count", queue_count, 3);
      check("t5_pre_req", imem_req, 0);
      drive(1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 1);
      check("t5_count", queue_count, 0);
      check("t5_valid", insn_valid, 0);
      check("t5_addr", imem_addr, 12'h000);
      check("t5_req", imem_req, 1);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) drive(0, 0, 0, 1);
         if (k == 2) check("t5_first_pc", insn_pc, 12'h000);
         tick();
      end

      // Random ready and redirects
      pops0 = pops;
      for (int k = 0; k < 1000; k++) begin
         drive(0, ($urandom_range(0, 19) == 0), 12'($urandom_range(0, 4095)),
               1'($urandom_range(0, 1)));
         check("rnd_valid_count", insn_valid, queue_count != 0);
         check("rnd_count_bound", queue_count <= 3'd4, 1);
         tick();
      end
      check("rnd_progress", (pops - pops0) > 100, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
